// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths and the slave state encoding.
package wb_pkg;

  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_t;

endpackage

// File: rtl/ram_sp_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Only the read register is reset; the array keeps its contents across reset.
module ram_sp_be
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en,
  input  logic [WB_SEL_W-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WB_DAT_W-1:0]   wdata,
  output logic [WB_DAT_W-1:0]   rdata
);

  logic [WB_DAT_W-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Byte-lane writes: each enabled lane updates its own 8 bits of the word.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (wr_be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register only loads on a read, so it holds the last read word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave in front of a byte-writable RAM, with optional
// wait states, address decode and error termination.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o
);

  localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  wb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ack_q, ack_d;
  logic err_q, err_d;

  logic                  we_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [WB_DAT_W-1:0]   dat_q;

  logic                  req_ok;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] adr_idx;
  logic                  latch;

  logic                  ram_rd_en;
  logic [WB_SEL_W-1:0]   ram_wr_be;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WB_DAT_W-1:0]   ram_wdata;

  // A strobe still held during our own ack/err cycle must not be taken again,
  // and nothing is accepted while reset is asserted.
  assign req_ok   = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q & ~rst_i;
  assign addr_err = (wb_adr_i[1:0] != 2'b00) ||
                    (wb_adr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
  assign adr_idx  = wb_adr_i[ADDR_WIDTH+1:2];

  // State, wait counter and registered terminations.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Request capture for the wait-state path; no reset needed since these are
  // only consumed after a fresh acceptance.
  always_ff @(posedge clk_i) begin
    if (latch) begin
      we_q  <= wb_we_i;
      sel_q <= wb_sel_i;
      idx_q <= adr_idx;
      dat_q <= wb_dat_i;
    end
  end

  // Next-state logic; the RAM is accessed on the same edge that raises ack,
  // so a zero-wait access uses the live bus and a waited one the captured copy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    latch     = 1'b0;
    ram_rd_en = 1'b0;
    ram_wr_be = '0;
    ram_addr  = idx_q;
    ram_wdata = dat_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          latch = 1'b1;
          cnt_d = '0;
          if (addr_err) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_d   = RESP;
            ack_d     = 1'b1;
            ram_addr  = adr_idx;
            ram_wdata = wb_dat_i;
            ram_rd_en = ~wb_we_i;
            ram_wr_be = wb_we_i ? wb_sel_i : '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!(wb_cyc_i && wb_stb_i)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d   = RESP;
          cnt_d     = '0;
          ack_d     = 1'b1;
          ram_rd_en = ~we_q;
          ram_wr_be = we_q ? sel_q : '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  ram_sp_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rd_en (ram_rd_en),
    .wr_be (ram_wr_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (wb_dat_o)
  );

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: one zero-wait instance and one three-wait instance,
// table-driven single accesses plus abort, back-to-back and reset sequences.
module tb_wb_ram_slave;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] adr   [2];
  logic [31:0] dat_i [2];
  logic [31:0] dat_o [2];
  logic        ack   [2];
  logic        err   [2];

  int n_checks = 0;
  int n_fails  = 0;
  exp_t sb[$];
  vec_t tbl[18];

  always #5 clk = ~clk;

  wb_ram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0])
  );

  wb_ram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request on instance d and queue what the slave must answer.
  task automatic applyStimulus(input int d, input vec_t v);
    exp_t e;
    cyc[d]   = 1'b1;
    stb[d]   = 1'b1;
    we[d]    = v.we;
    sel[d]   = v.sel;
    adr[d]   = v.adr;
    dat_i[d] = v.dat;
    e.err = v.exp_err;
    e.dat = v.exp_dat;
    e.lat = v.exp_err ? 1 : ((d == 1) ? 4 : 1);
    sb.push_back(e);
  endtask

  // Wait (bounded) for the termination, compare against the queued entry,
  // release the bus and confirm the termination lasted one cycle.
  task automatic checkOutput(input int d, input string name);
    exp_t e;
    int   n;
    logic got_ack, got_err;
    e = sb.pop_front();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack[d] || err[d]) && n < 40);
    got_ack = ack[d];
    got_err = err[d];
    check({name, "_lat"}, 32'(n), 32'(e.lat));
    check({name, "_ack"}, 32'(got_ack), 32'(!e.err));
    check({name, "_err"}, 32'(got_err), 32'(e.err));
    check({name, "_dat"}, dat_o[d], e.dat);
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
    @(negedge clk);
    check({name, "_one_cycle"}, 32'(ack[d] | err[d]), 32'h0);
  endtask

  task automatic access(input int d, input string name, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e, input logic [31:0] ed);
    vec_t v;
    v = '{we: w, sel: s, adr: a, dat: wd, exp_err: e, exp_dat: ed};
    applyStimulus(d, v);
    checkOutput(d, name);
  endtask

  initial begin
    int acks, errs, gap_bad, last, first, seen;
    logic adv;

    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks, errs, gap_bad, last, first, seen;
    logic adv;

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 4'hF, 32'h0000_0014, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 4'h5, 32'h0000_0014, 32'h11223344, 1'b0, 32'hDEADBEEF};
    tbl[4]  = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,        1'b0, 32'hAA22CC44};
    tbl[5]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0BADF00D, 1'b0, 32'hAA22CC44};
    tbl[6]  = '{1'b1, 4'hF, 32'h0000_4000, 32'h12345678, 1'b1, 32'hAA22CC44};
    tbl[7]  = '{1'b0, 4'hF, 32'h0000_0002, 32'h0,        1'b1, 32'hAA22CC44};
    tbl[8]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,        1'b0, 32'h0BADF00D};
    tbl[9]  = '{1'b1, 4'hF, 32'h0000_0012, 32'hCAFEF00D, 1'b1, 32'h0BADF00D};
    tbl[10] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFFFFFF, 1'b0, 32'hDEADBEEF};
    tbl[12] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 4'hF, 32'h0000_3FFC, 32'h76543210, 1'b0, 32'hDEADBEEF};
    tbl[14] = '{1'b0, 4'hF, 32'h0000_3FFC, 32'h0,        1'b0, 32'h76543210};
    tbl[15] = '{1'b0, 4'hF, 32'h8000_0010, 32'h0,        1'b1, 32'h76543210};
    tbl[16] = '{1'b1, 4'h8, 32'h0000_0010, 32'hEE000000, 1'b0, 32'h76543210};
    tbl[17] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        1'b0, 32'hEEADBEEF};

    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = 4'h0; adr[d] = 32'h0; dat_i[d] = 32'h0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ack%0d", d), 32'(ack[d]), 32'h0);
      check($sformatf("reset_err%0d", d), 32'(err[d]), 32'h0);
      check($sformatf("reset_dat%0d", d), dat_o[d], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, tbl[i]);
      checkOutput(0, $sformatf("vec%0d", i));
    end

    // Registered master: strobe held through each ack cycle, address advanced
    // only after the edge that ends the ack.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    adr[0] = 32'h0000_0100; dat_i[0] = 32'hA000_0000;
    acks = 0; errs = 0; gap_bad = 0; last = 0; first = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      adv = 1'b0;
      if (err[0]) errs++;
      if (ack[0]) begin
        if (acks == 0) first = c;
        else if (c - last != 2) gap_bad++;
        last = c;
        acks++;
        adv = 1'b1;
      end
      @(posedge clk);
      #1;
      if (adv) begin
        if (acks < 4) begin
          adr[0]   = 32'h0000_0100 + 32'(4 * acks);
          dat_i[0] = 32'hA000_0000 + 32'(acks);
        end else begin
          cyc[0] = 1'b0;
          stb[0] = 1'b0;
        end
      end
    end
    check("b2b_acks", 32'(acks), 32'd4);
    check("b2b_errs", 32'(errs), 32'd0);
    check("b2b_gap", 32'(gap_bad), 32'd0);
    check("b2b_first", 32'(first), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      access(0, $sformatf("b2b_rd%0d", i), 1'b0, 4'hF, 32'h0000_0100 + 32'(4 * i), 32'h0,
             1'b0, 32'hA000_0000 + 32'(i));
    end

    // Three-wait instance: ack latency, error latency, abort.
    access(1, "w3_wr20", 1'b1, 4'hF, 32'h0000_0020, 32'h5A5A5A5A, 1'b0, 32'h0);
    access(1, "w3_rd20", 1'b0, 4'hF, 32'h0000_0020, 32'h0, 1'b0, 32'h5A5A5A5A);
    access(1, "w3_err", 1'b1, 4'hF, 32'h0000_4000, 32'h0, 1'b1, 32'h5A5A5A5A);

    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
    adr[1] = 32'h0000_0020; dat_i[1] = 32'hFFFF_FFFF;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack[1] | err[1]) seen++;
    end
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] | err[1]) seen++;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    access(1, "abort_rd20", 1'b0, 4'hF, 32'h0000_0020, 32'h0, 1'b0, 32'h5A5A5A5A);

    // Reset during a waited write must drop it without touching memory.
    access(1, "rst_wr30", 1'b1, 4'hF, 32'h0000_0030, 32'h13572468, 1'b0, 32'h5A5A5A5A);
    access(1, "rst_rd30", 1'b0, 4'hF, 32'h0000_0030, 32'h0, 1'b0, 32'h13572468);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
    adr[1] = 32'h0000_0030; dat_i[1] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    @(negedge clk);
    check("midrst_ack", 32'(ack[1]), 32'h0);
    check("midrst_err", 32'(err[1]), 32'h0);
    check("midrst_dat", dat_o[1], 32'h0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack[1] | err[1]) seen++;
    end
    check("midrst_no_resp", 32'(seen), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    access(1, "postrst_rd30", 1'b0, 4'hF, 32'h0000_0030, 32'h0, 1'b0, 32'h13572468);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
